// File: rtl/b16_bitplane_serializer.sv
// Bit-plane serializer: takes a vector of LANES words and emits MSB-first bit-planes with framing.
// Optional macro BPS_SIGNED_EN flags the sign plane on out_neg for two's-complement words.
module b16_bitplane_serializer #(
    parameter int unsigned LANES = 16,
    parameter int unsigned WMAX  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*WMAX-1:0] in_data,
    input  logic [4:0]            in_prec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_bits,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  out_neg,
    output logic                  busy
);

    localparam int unsigned KW = $clog2(WMAX);

    typedef enum logic {StIdle, StShift} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d, k_dec, eff_pm1;
    logic [WMAX-1:0]     words_q [LANES];
    logic [WMAX-1:0]     words_d [LANES];
    logic [LANES-1:0]    bits_q, bits_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                neg_d;
    logic                load, hs;

    // Out-of-range precision (0 or above WMAX) falls back to full width.
    always_comb begin
        if (in_prec == 5'd0 || 32'(in_prec) > WMAX) begin
            eff_pm1 = KW'(WMAX - 1);
        end else begin
            eff_pm1 = KW'(in_prec - 5'd1);
        end
    end

    assign in_ready  = !rst && ((state_q == StIdle) ||
                                (state_q == StShift && k_q == '0 && out_ready));
    assign load      = in_valid && in_ready;
    assign out_valid = (state_q == StShift);
    assign hs        = out_valid && out_ready;
    assign busy      = (state_q == StShift);
    assign k_dec     = k_q - KW'(1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        words_d = words_q;
        bits_d  = bits_q;
        first_d = first_q;
        last_d  = last_q;
        neg_d   = 1'b0;
        if (load) begin
            state_d = StShift;
            k_d     = eff_pm1;
            first_d = 1'b1;
            last_d  = (eff_pm1 == '0);
            neg_d   = 1'b1;
            for (int i = 0; i < int'(LANES); i++) begin
                words_d[i] = in_data[int'(WMAX)*i +: WMAX];
                bits_d[i]  = in_data[int'(WMAX)*i + int'(eff_pm1)];
            end
        end else if (hs) begin
            if (k_q == '0) begin
                state_d = StIdle;
                bits_d  = '0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                k_d     = k_dec;
                first_d = 1'b0;
                last_d  = (k_dec == '0);
                for (int i = 0; i < int'(LANES); i++) begin
                    bits_d[i] = words_q[i][k_dec];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            words_q <= '{default: '0};
            bits_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            words_q <= words_d;
            bits_q  <= bits_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign out_bits  = bits_q;
    assign out_first = first_q;
    assign out_last  = last_q;

`ifdef BPS_SIGNED_EN
    // Sign plane is always the first plane of a vector, so neg is only set on load.
    logic neg_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else if (load || hs) begin
            neg_q <= load ? neg_d : 1'b0;
        end
    end
    assign out_neg = neg_q;
`else
    assign out_neg = 1'b0;
`endif

endmodule

// File: tb/tb_b16_bitplane_serializer.sv
// Directed self-checking bench for b16_bitplane_serializer; inputs driven and outputs
// sampled on the falling clock edge.
module tb_b16_bitplane_serializer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [255:0]  in_data;
    logic [4:0]    in_prec;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_bits;
    logic          out_first;
    logic          out_last;
    logic          out_neg;
    logic          busy;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int n;

`ifdef BPS_SIGNED_EN
    localparam logic SIGNED = 1'b1;
`else
    localparam logic SIGNED = 1'b0;
`endif

    always #5 clk = ~clk;

    b16_bitplane_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_prec   (in_prec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_first (out_first),
        .out_last  (out_last),
        .out_neg   (out_neg),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plane tuple {valid, first, last, bits}.
    task automatic chk_plane(input string tag, input logic [15:0] bits, input logic first,
                             input logic last);
        chk(tag, {13'd0, out_valid, out_first, out_last, out_bits},
            {13'd0, 1'b1, first, last, bits});
    endtask

    task automatic count_planes(output int cnt);
        cnt = 0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_prec = 5'd0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outs", {out_valid, out_first, out_last, out_neg, busy, out_bits}, 0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // P=4, lane i = i
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'(i);
        in_prec = 5'd4; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk_plane("p4_k3", 16'hFF00, 1, 0);
        chk("p4_busy", busy, 1);
        @(negedge clk); chk_plane("p4_k2", 16'hF0F0, 0, 0);
        @(negedge clk); chk_plane("p4_k1", 16'hCCCC, 0, 0);
        @(negedge clk); chk_plane("p4_k0", 16'hAAAA, 0, 1);
        @(negedge clk); chk("p4_done", {out_valid, busy}, 0);

        // Back-to-back P=2 vectors: A lane i = i&3, B all ones
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'(i % 4);
        in_prec = 5'd2; in_valid = 1'b1;
        @(negedge clk);
        chk_plane("b2b_a1", 16'hCCCC, 1, 0);
        chk("b2b_a1_ready", in_ready, 0);
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'd1;
        @(negedge clk);
        chk_plane("b2b_a0", 16'hAAAA, 0, 1);
        chk("b2b_a0_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        chk_plane("b2b_b1", 16'h0000, 1, 0);
        @(negedge clk); chk_plane("b2b_b0", 16'hFFFF, 0, 1);
        @(negedge clk); chk("b2b_done", out_valid, 0);

        // Backpressure: P=16, all lanes 0x8001
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'h8001;
        in_prec = 5'd16; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        chk_plane("bp_k15", 16'hFFFF, 1, 0);
        @(negedge clk); chk_plane("bp_stall1", 16'hFFFF, 1, 0);
        @(negedge clk); chk_plane("bp_stall2", 16'hFFFF, 1, 0);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            chk("bp_plane", out_bits, (n == 0 || n == 15) ? 16'hFFFF : 16'h0000);
            n++;
            @(negedge clk);
        end
        chk("bp_count", n, 16);

        // Precision fallback and P=1
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'(i);
        in_prec = 5'd0; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        count_planes(n); chk("prec0_count", n, 16);
        in_prec = 5'd20; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        count_planes(n); chk("prec20_count", n, 16);
        in_prec = 5'd1; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk_plane("prec1", 16'hAAAA, 1, 1);
        @(negedge clk); chk("prec1_done", out_valid, 0);

        // Reset mid-vector at k=7
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'hFFFF;
        in_prec = 5'd16; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk_plane("mid_k7", 16'hFFFF, 0, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {out_valid, out_first, out_last, out_neg, busy, out_bits}, 0);
        chk("mid_rst_ready", in_ready, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("mid_rel_ready", in_ready, 1);
        for (int i = 0; i < 16; i++) in_data[16*i +: 16] = 16'(i);
        in_prec = 5'd4; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk_plane("mid_new_first", 16'hFF00, 1, 0);
        count_planes(n); chk("mid_new_count", n, 4);

        // Sign plane: P=8, lane 0 = 0x80
        in_data = '0; in_data[15:0] = 16'h0080;
        in_prec = 5'd8; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        chk_plane("sgn_p1", 16'h0001, 1, 0);
        chk("sgn_p1_neg", out_neg, SIGNED);
        @(negedge clk);
        chk_plane("sgn_p2", 16'h0000, 0, 0);
        chk("sgn_p2_neg", out_neg, 0);
        repeat (6) @(negedge clk);
        chk_plane("sgn_p8", 16'h0000, 0, 1);
        chk("sgn_p8_neg", out_neg, 0);
        @(negedge clk); chk("sgn_done", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
